// File: rtl/parallel_gate_skid_pkg.sv
// Shared state codes and width helper for the parallel gate skid stage.
package parallel_gate_skid_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   // Bus width for a given log2 size, common to the parallel gate family.
   function automatic int gate_width(input int s);
      return 2 ** s;
   endfunction

endpackage

// File: rtl/parallel_gate_skid_dffe.sv
// W-bit enabled D register with synchronous clear, built by recursive halving
// down to a 1-bit leaf so it matches the other parallel primitives.
module gate_dffe (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk) begin
      if (clr)     q <= 1'b0;
      else if (en) q <= d;
   end
endmodule

module parallel_gate_dffe
   import parallel_gate_skid_pkg::*;
#(
   parameter int S = 3
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     en,
   input  logic [gate_width(S)-1:0] d,
   output logic [gate_width(S)-1:0] q
);
   generate
      if (S == 0) begin : g_leaf
         gate_dffe u_bit (
            .clk (clk),
            .clr (clr),
            .en  (en),
            .d   (d[0]),
            .q   (q[0])
         );
      end else begin : g_split
         localparam int H = gate_width(S - 1);
         parallel_gate_dffe #(.S(S - 1)) u_lo (
            .clk (clk),
            .clr (clr),
            .en  (en),
            .d   (d[H-1:0]),
            .q   (q[H-1:0])
         );
         parallel_gate_dffe #(.S(S - 1)) u_hi (
            .clk (clk),
            .clr (clr),
            .en  (en),
            .d   (d[2*H-1:H]),
            .q   (q[2*H-1:H])
         );
      end
   endgenerate
endmodule

// File: rtl/parallel_gate_skid.sv
// Registered valid/ready skid stage: main drives out_data, skid absorbs the
// one word in flight when downstream stalls, so in_ready never sees out_ready.
module parallel_gate_skid
   import parallel_gate_skid_pkg::*;
#(
   parameter int S = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [gate_width(S)-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [gate_width(S)-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               occupancy
);
   localparam int W = gate_width(S);

   skid_state_e    state, state_nxt;
   logic           in_x, out_x;
   logic           main_en, skid_en, main_from_skid;
   logic [W-1:0]   main_d, skid_q;

   assign in_x  = in_valid && in_ready;
   assign out_x = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         ST_ONE: begin
            if (in_x && out_x) begin
               main_en = 1'b1;
            end else if (in_x) begin
               skid_en   = 1'b1;
               state_nxt = ST_FULL;
            end else if (out_x) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_x) begin
               main_en        = 1'b1;
               main_from_skid = 1'b1;
               state_nxt      = ST_ONE;
            end
         end
         default: begin
            // Illegal code 3 behaves as EMPTY.
            state_nxt = ST_EMPTY;
            if (in_x) begin
               main_en   = 1'b1;
               state_nxt = ST_ONE;
            end
         end
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      in_ready  = !rst;
      occupancy = 2'd0;
      case (state)
         ST_ONE: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         ST_FULL: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
            occupancy = 2'd2;
         end
         default: ;
      endcase
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   parallel_gate_dffe #(.S(S)) u_main (
      .clk (clk),
      .clr (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (out_data)
   );

   parallel_gate_dffe #(.S(S)) u_skid (
      .clk (clk),
      .clr (rst),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
   );
endmodule

// File: tb/tb_parallel_gate_skid.sv
// Directed and randomized checks of the skid stage at S=3, S=0 and S=5.
module tb_parallel_gate_skid;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // S=3 instance for directed vectors
   logic [7:0] d_in_data = '0, d_out_data;
   logic       d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
   logic [1:0] d_occ;

   parallel_gate_skid #(.S(3)) u_d (
      .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid),
      .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .occupancy(d_occ)
   );

   // S=0 and S=5 instances for random traffic
   logic [0:0]  a_in_data = '0, a_out_data;
   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
   logic [1:0]  a_occ;
   logic [31:0] b_in_data = '0, b_out_data;
   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
   logic [1:0]  b_occ;

   parallel_gate_skid #(.S(0)) u_a (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .occupancy(a_occ)
   );

   parallel_gate_skid #(.S(5)) u_b (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .occupancy(b_occ)
   );

   logic [31:0] qa[$];
   logic [31:0] qb[$];

   initial begin
      logic        a_stall, b_stall;
      logic [31:0] a_prev, b_prev;

      // Reset with a word offered
      rst = 1'b1; d_in_valid = 1'b1; d_in_data = 8'hFF;
      tick(); tick(); tick();
      chk("rst_out_valid", {31'd0, d_out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, d_out_data},  32'd0);
      chk("rst_occ",       {30'd0, d_occ},       32'd0);
      chk("rst_in_ready",  {31'd0, d_in_ready},  32'd0);
      rst = 1'b0; d_in_valid = 1'b0;
      #1;
      chk("rel_in_ready",  {31'd0, d_in_ready},  32'd1);

      // Single word
      d_in_data = 8'hA5; d_in_valid = 1'b1; d_out_ready = 1'b1;
      tick();
      d_in_valid = 1'b0;
      chk("one_data",  {24'd0, d_out_data},  32'hA5);
      chk("one_valid", {31'd0, d_out_valid}, 32'd1);
      chk("one_occ",   {30'd0, d_occ},       32'd1);
      tick();
      chk("one_drain_occ",   {30'd0, d_occ},       32'd0);
      chk("one_drain_valid", {31'd0, d_out_valid}, 32'd0);

      // Fill and stall
      d_out_ready = 1'b0; d_in_valid = 1'b1; d_in_data = 8'h11;
      tick();
      chk("fill1_occ", {30'd0, d_occ}, 32'd1);
      d_in_data = 8'h22;
      tick();
      chk("fill2_occ",   {30'd0, d_occ},      32'd2);
      chk("fill2_ready", {31'd0, d_in_ready}, 32'd0);
      chk("fill2_data",  {24'd0, d_out_data}, 32'h11);
      d_in_data = 8'h33;
      tick();
      chk("full_hold_occ",  {30'd0, d_occ},      32'd2);
      chk("full_hold_data", {24'd0, d_out_data}, 32'h11);
      d_in_valid = 1'b0; d_out_ready = 1'b1;
      tick();
      chk("drain1_data",  {24'd0, d_out_data}, 32'h22);
      chk("drain1_occ",   {30'd0, d_occ},      32'd1);
      chk("drain1_ready", {31'd0, d_in_ready}, 32'd1);
      tick();
      chk("drain2_occ", {30'd0, d_occ}, 32'd0);

      // Streaming 0..15
      d_in_valid = 1'b1; d_out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         d_in_data = 8'(i);
         tick();
         chk("stream_data",  {24'd0, d_out_data},  32'(i));
         chk("stream_valid", {31'd0, d_out_valid}, 32'd1);
         chk("stream_occ",   {30'd0, d_occ},       32'd1);
      end
      d_in_valid = 1'b0;
      tick();
      chk("stream_end_occ", {30'd0, d_occ}, 32'd0);

      // Reset while FULL
      d_out_ready = 1'b0; d_in_valid = 1'b1; d_in_data = 8'hAA;
      tick();
      d_in_data = 8'hBB;
      tick();
      chk("pre_rst_occ", {30'd0, d_occ}, 32'd2);
      rst = 1'b1; d_in_data = 8'hDD; d_out_ready = 1'b1;
      tick();
      chk("mid_rst_occ",   {30'd0, d_occ},       32'd0);
      chk("mid_rst_valid", {31'd0, d_out_valid}, 32'd0);
      chk("mid_rst_data",  {24'd0, d_out_data},  32'd0);
      chk("mid_rst_ready", {31'd0, d_in_ready},  32'd0);
      rst = 1'b0; d_in_data = 8'hCC; d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      chk("post_rst_data",  {24'd0, d_out_data},  32'hCC);
      chk("post_rst_valid", {31'd0, d_out_valid}, 32'd1);
      tick();
      chk("post_rst_occ", {30'd0, d_occ}, 32'd0);

      // Random traffic on S=0 and S=5, then a drain phase
      a_stall = 1'b0; b_stall = 1'b0; a_prev = '0; b_prev = '0;
      for (int c = 0; c < 1040; c++) begin
         a_in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         a_out_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
         a_in_data   = 1'($urandom);
         b_in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         b_out_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
         b_in_data   = $urandom;
         if (a_stall) chk("s0_stall_stable", {31'd0, a_out_data}, a_prev);
         if (b_stall) chk("s5_stall_stable", b_out_data, b_prev);
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("s0_extra_word", 32'd1, 32'd0);
            else chk("s0_order", {31'd0, a_out_data}, qa.pop_front());
         end
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("s5_extra_word", 32'd1, 32'd0);
            else chk("s5_order", b_out_data, qb.pop_front());
         end
         if (a_in_valid && a_in_ready) qa.push_back({31'd0, a_in_data});
         if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
         a_stall = a_out_valid && !a_out_ready; a_prev = {31'd0, a_out_data};
         b_stall = b_out_valid && !b_out_ready; b_prev = b_out_data;
         tick();
      end
      chk("s0_lossless", 32'(qa.size()), 32'd0);
      chk("s5_lossless", 32'(qb.size()), 32'd0);
      chk("s0_idle_occ", {30'd0, a_occ}, 32'd0);
      chk("s5_idle_occ", {30'd0, b_occ}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
